// File: rtl/bus_pkg.sv
// Shared bus definitions: slave ids and requester state encoding.
// Used by the requester, the arbiter and the slave mux.
package bus_pkg;
  localparam int SLAVE_ID_W = 2;
  typedef logic [SLAVE_ID_W-1:0] slave_id_t;

  localparam slave_id_t SLV_0 = 2'd0;
  localparam slave_id_t SLV_1 = 2'd1;
  localparam slave_id_t SLV_2 = 2'd2;
  localparam slave_id_t SLV_3 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ARB_WAIT,
    ADDR_MSB,
    ADDR_LSB,
    WAIT_GRANT,
    OWNED,
    BACKOFF
  } req_state_e;
endpackage

// File: rtl/bus_master_requester_if.sv
// Requester-side signal bundle: local command handshake plus arbiter wires.
// The master modport is the requester's view; slave is the core/arbiter view.
interface bus_master_requester_if;
  import bus_pkg::*;
  logic      cmd_valid;
  logic      cmd_ready;
  slave_id_t cmd_slave;
  logic      xfer_done;
  logic      arbiter_busy;
  logic      grant;
  logic      request;
  logic      slave_sel;
  logic      bus_owned;
  logic      req_error;
  logic [1:0] retry_cnt;

  modport master (
    input  cmd_valid, cmd_slave, xfer_done, arbiter_busy, grant,
    output cmd_ready, request, slave_sel, bus_owned, req_error, retry_cnt
  );
  modport slave (
    output cmd_valid, cmd_slave, xfer_done, arbiter_busy, grant,
    input  cmd_ready, request, slave_sel, bus_owned, req_error, retry_cnt
  );
endinterface

// File: rtl/req_down_counter.sv
// Loadable down-counter with zero flag; load wins over decrement and the
// count holds at zero.
module req_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                        r_cnt <= '0;
    else if (i_load)                r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/bus_master_requester.sv
// Master-side arbitration initiator: one-cycle request, 2-cycle MSB-first slave
// select, win/loss tracking with retries and timeout. REQ_RETRY_BACKOFF_EN adds
// exponential backoff between retries.
module bus_master_requester
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRIES    = 3
`ifdef REQ_RETRY_BACKOFF_EN
 ,parameter int BACKOFF_CYCLES = 4
`endif
) (
  input logic                    sys_clk,
  input logic                    sys_rst,
  bus_master_requester_if.master bus
);
  localparam int       TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_R8 = 8'(MAX_RETRIES);

  req_state_e r_state, w_nxt;
  slave_id_t  r_slave;
  logic [7:0] r_retry;
  logic       r_req_error;

  logic w_loss, w_err, w_retry_inc, w_to_load, w_to_dec, w_to_zero;

`ifdef REQ_RETRY_BACKOFF_EN
  localparam int BW = $clog2((BACKOFF_CYCLES << MAX_RETRIES) + 1);
  logic w_bo_load, w_bo_dec, w_bo_zero;
  logic [BW-1:0] w_bo_val;

  // Gap length uses the retry count before this loss: 1x, 2x, 4x ...
  assign w_bo_val = BW'((BACKOFF_CYCLES << r_retry) - 1);

  req_down_counter #(.W(BW)) u_backoff (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .i_load     (w_bo_load),
    .i_load_val (w_bo_val),
    .i_dec      (w_bo_dec),
    .o_zero     (w_bo_zero)
  );
`endif

  // Loaded with N-1 so the zero flag marks the N-th busy cycle in WAIT_GRANT.
  req_down_counter #(.W(TW)) u_timeout (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .i_load     (w_to_load),
    .i_load_val (TW'(TIMEOUT_CYCLES - 1)),
    .i_dec      (w_to_dec),
    .o_zero     (w_to_zero)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    w_loss      = 1'b0;
    w_err       = 1'b0;
    w_retry_inc = 1'b0;
    w_to_load   = 1'b0;
    w_to_dec    = 1'b0;
`ifdef REQ_RETRY_BACKOFF_EN
    w_bo_load   = 1'b0;
    w_bo_dec    = 1'b0;
`endif
    case (r_state)
      IDLE:       if (bus.cmd_valid) w_nxt = ARB_WAIT;
      ARB_WAIT:   if (!bus.arbiter_busy) w_nxt = ADDR_MSB;
      ADDR_MSB:   w_nxt = ADDR_LSB;
      ADDR_LSB: begin
        if (!bus.arbiter_busy) w_loss = 1'b1;
        else begin
          w_to_load = 1'b1;
          w_nxt     = WAIT_GRANT;
        end
      end
      WAIT_GRANT: begin
        // grant is only trusted on the busy fall that follows our own request
        if (!bus.arbiter_busy) begin
          if (bus.grant) w_nxt = OWNED;
          else           w_loss = 1'b1;
        end else if (w_to_zero) begin
          w_err = 1'b1;
          w_nxt = IDLE;
        end else begin
          w_to_dec = 1'b1;
        end
      end
      OWNED:      if (bus.xfer_done) w_nxt = IDLE;
`ifdef REQ_RETRY_BACKOFF_EN
      BACKOFF: begin
        if (w_bo_zero) w_nxt = ARB_WAIT;
        else           w_bo_dec = 1'b1;
      end
`endif
      default:    w_nxt = IDLE;
    endcase

    if (w_loss) begin
      if (r_retry < MAX_R8) begin
        w_retry_inc = 1'b1;
`ifdef REQ_RETRY_BACKOFF_EN
        w_bo_load   = 1'b1;
        w_nxt       = BACKOFF;
`else
        w_nxt       = ARB_WAIT;
`endif
      end else begin
        w_err = 1'b1;
        w_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_slave     <= '0;
      r_retry     <= '0;
      r_req_error <= 1'b0;
    end else begin
      r_req_error <= w_err;
      if (r_state == IDLE && bus.cmd_valid) begin
        r_slave <= bus.cmd_slave;
        r_retry <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 8'd1;
      end
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.request   = (r_state == ADDR_MSB);
  assign bus.slave_sel = (r_state == ADDR_MSB) ? r_slave[1] :
                         (r_state == ADDR_LSB) ? r_slave[0] : 1'b0;
  assign bus.bus_owned = (r_state == OWNED);
  assign bus.req_error = r_req_error;
  assign bus.retry_cnt = (r_retry > 8'd3) ? 2'd3 : r_retry[1:0];
endmodule

// File: tb/tb_bus_master_requester.sv
// Scoreboard bench for bus_master_requester: directed scenarios push expected
// events; a negedge monitor detects DUT events and compares them in order.
module tb_bus_master_requester;
  localparam int K_REQ = 0, K_OWN = 1, K_REL = 2, K_ERR = 3;
`ifdef REQ_RETRY_BACKOFF_EN
  localparam bit BO_EN = 1'b1;
`else
  localparam bit BO_EN = 1'b0;
`endif

  typedef struct {
    int         kind;
    string      name;
    logic [3:0] data;
    int         gap;
  } ev_t;

  logic sys_clk, sys_rst;
  bus_master_requester_if bus();

  bus_master_requester #(.TIMEOUT_CYCLES(16), .MAX_RETRIES(3)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  // Request-to-request gap after a loss: 5 cycles plus the backoff wait.
  function automatic int gap_loss(input int n);
    return 5 + (BO_EN ? (4 << n) : 0);
  endfunction

  task automatic push(input int k, input string nm, input logic [3:0] d, input int g);
    ev_t e;
    e.kind = k; e.name = nm; e.data = d; e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cmp_ev(input int k, input logic [3:0] d, input int g);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got kind=%0d data=%h gap=%0d want no event", k, d, g);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.data !== d || (e.gap >= 0 && e.gap != g)) begin
      n_errors++;
      $display("FAIL %s: got kind=%0d data=%h gap=%0d want kind=%0d data=%h gap=%0d",
               e.name, k, d, g, e.kind, e.data, e.gap);
    end
  endtask

  // Monitor
  int         m_cyc = 0, m_last = 0, m_req_gap = 0, m_err_gap = 0;
  bit         m_preq = 1'b0, m_perr = 1'b0, m_prev_own = 1'b0;
  logic       m_msb;
  logic [2:0] m_err_d;

  initial begin
    forever begin
      @(negedge sys_clk);
      m_cyc++;
      if (m_preq) begin
        cmp_ev(K_REQ, {1'b0, bus.request, m_msb, bus.slave_sel}, m_req_gap);
        m_preq = 1'b0;
      end
      if (m_perr) begin
        cmp_ev(K_ERR, {m_err_d[2], bus.req_error, m_err_d[1:0]}, m_err_gap);
        m_perr = 1'b0;
      end
      if (sys_rst === 1'b0 && bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) m_last = m_cyc;
      if (bus.request === 1'b1) begin
        m_preq = 1'b1; m_msb = bus.slave_sel; m_req_gap = m_cyc - m_last; m_last = m_cyc;
      end
      if (bus.bus_owned === 1'b1 && !m_prev_own) begin
        cmp_ev(K_OWN, {2'b00, bus.retry_cnt}, m_cyc - m_last);
        m_last = m_cyc;
      end
      if (bus.bus_owned === 1'b0 && m_prev_own) cmp_ev(K_REL, {3'b000, bus.cmd_ready}, -1);
      if (bus.req_error === 1'b1) begin
        m_perr = 1'b1; m_err_d = {bus.cmd_ready, bus.retry_cnt}; m_err_gap = m_cyc - m_last;
        m_last = m_cyc;
      end
      m_prev_own = (bus.bus_owned === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] s);
    @(posedge sys_clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_slave = s;
    @(posedge sys_clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge sys_clk);
      if (bus.request === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL wait_req: got no request within 80 cycles want request");
    end
  endtask

  // Arbiter accepts the request, stays busy for `hold` cycles, then resolves.
  task automatic arb(input bit win, input int hold);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    @(posedge sys_clk); #1 bus.arbiter_busy = 1'b1;
    repeat (hold) @(posedge sys_clk);
    #1 bus.arbiter_busy = 1'b0; bus.grant = win;
  endtask

  task automatic release_bus();
    repeat (2) @(posedge sys_clk);
    #1 bus.xfer_done = 1'b1;
    @(posedge sys_clk); #1 bus.xfer_done = 1'b0; bus.grant = 1'b0;
    @(negedge sys_clk);
    chk("release_bus_owned", {7'd0, bus.bus_owned}, 8'd0);
    chk("release_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
  endtask

  task automatic pulse_reset();
    @(posedge sys_clk); #1 sys_rst = 1'b1;
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  initial begin
    bit ok;
    bus.cmd_valid = 1'b0; bus.cmd_slave = 2'b00; bus.xfer_done = 1'b0;
    bus.arbiter_busy = 1'b0; bus.grant = 1'b0;
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
    chk("rst_request",   {7'd0, bus.request},   8'd0);
    chk("rst_slave_sel", {7'd0, bus.slave_sel}, 8'd0);
    chk("rst_bus_owned", {7'd0, bus.bus_owned}, 8'd0);
    chk("rst_req_error", {7'd0, bus.req_error}, 8'd0);
    chk("rst_retry_cnt", {6'd0, bus.retry_cnt}, 8'd0);

    // Uncontended, slave 2'b10
    push(K_REQ, "unc_addr", 4'b0010, 2);
    push(K_OWN, "unc_own",  4'd0, 4);
    push(K_REL, "unc_rel",  4'd1, -1);
    issue(2'b10);
    arb(1'b1, 2);
    release_bus();

    // Arbiter busy for 5 cycles at accept
    push(K_REQ, "busy_addr", 4'b0001, 6);
    push(K_OWN, "busy_own",  4'd0, 4);
    push(K_REL, "busy_rel",  4'd1, -1);
    @(posedge sys_clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_slave = 2'b01; bus.arbiter_busy = 1'b1;
    @(posedge sys_clk); #1 bus.cmd_valid = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1 bus.arbiter_busy = 1'b0;
    arb(1'b1, 2);
    release_bus();

    // Two losses then a win
    push(K_REQ, "loss_addr0", 4'b0011, 2);
    push(K_REQ, "loss_addr1", 4'b0011, gap_loss(0));
    push(K_REQ, "loss_addr2", 4'b0011, gap_loss(1));
    push(K_OWN, "loss_own",   4'd2, 4);
    push(K_REL, "loss_rel",   4'd1, -1);
    issue(2'b11);
    arb(1'b0, 2);
    arb(1'b0, 2);
    arb(1'b1, 2);
    release_bus();

    // Four losses exhaust MAX_RETRIES=3
    push(K_REQ, "exh_addr0", 4'b0000, 2);
    push(K_REQ, "exh_addr1", 4'b0000, gap_loss(0));
    push(K_REQ, "exh_addr2", 4'b0000, gap_loss(1));
    push(K_REQ, "exh_addr3", 4'b0000, gap_loss(2));
    push(K_ERR, "exh_err",   4'b1011, 4);
    issue(2'b00);
    repeat (4) arb(1'b0, 2);
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("exh_retry_hold", {6'd0, bus.retry_cnt}, 8'd3);

    // Timeout with a stale grant held high throughout
    bus.grant = 1'b1;
    push(K_REQ, "to_addr", 4'b0010, 2);
    push(K_ERR, "to_err",  4'b1000, 18);
    issue(2'b10);
    wait_req(ok);
    @(posedge sys_clk); #1 bus.arbiter_busy = 1'b1;
    repeat (24) @(posedge sys_clk);
    #1 bus.arbiter_busy = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1 bus.grant = 1'b0;
    @(negedge sys_clk);
    chk("to_not_owned", {7'd0, bus.bus_owned}, 8'd0);

    // Reset while OWNED
    push(K_REQ, "rown_addr", 4'b0001, 2);
    push(K_OWN, "rown_own",  4'd0, 4);
    push(K_REL, "rown_rel",  4'd1, -1);
    issue(2'b01);
    arb(1'b1, 2);
    pulse_reset();
    bus.grant = 1'b0;
    chk("rown_request",   {7'd0, bus.request},   8'd0);
    chk("rown_bus_owned", {7'd0, bus.bus_owned}, 8'd0);
    chk("rown_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);

    // Reset while WAIT_GRANT
    push(K_REQ, "rwg_addr", 4'b0011, 2);
    issue(2'b11);
    wait_req(ok);
    @(posedge sys_clk); #1 bus.arbiter_busy = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rwg_request",   {7'd0, bus.request},   8'd0);
    chk("rwg_bus_owned", {7'd0, bus.bus_owned}, 8'd0);
    chk("rwg_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
    chk("rwg_retry_cnt", {6'd0, bus.retry_cnt}, 8'd0);
    bus.arbiter_busy = 1'b0;

    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
